lpcm_seq_arbiter: RTL and testbench

LPCM_SEQ_ARBITER -- requirements
Module: lpcm_seq_arbiter

---
 rtl/lpcm_pkg.sv | 16 +
 rtl/lpcm_rr_picker.sv | 29 ++
 rtl/lpcm_seq_arbiter.sv | 111 +++++++++++
 tb/tb_lpcm_seq_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpcm_pkg.sv
// Shared types for the LPCM sequencer arbiter: transaction item and arbiter state.
package lpcm_pkg;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [15:0] addr;
    logic [31:0] data;
  } lpcm_item;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } lpcm_arb_state_e;

endpackage

// File: rtl/lpcm_rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo N_SEQ.
module lpcm_rr_picker #(
  parameter int unsigned N_SEQ = 4
) (
  input  logic [N_SEQ-1:0]         req,
  input  logic [$clog2(N_SEQ)-1:0] last,
  output logic                     valid,
  output logic [$clog2(N_SEQ)-1:0] index
);

  localparam int unsigned IW = $clog2(N_SEQ);

  logic [IW-1:0] cand;

  // Scan candidates last+1, last+2, ... last+N_SEQ and keep the first one requesting.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_SEQ; k++) begin
      cand = IW'((32'(last) + k) % N_SEQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/lpcm_seq_arbiter.sv
// Arbitrates N_SEQ sequencers onto one driver with a single outstanding item,
// round-robin selection, response routing, timeout and stray-response detection.
module lpcm_seq_arbiter
  import lpcm_pkg::*;
#(
  parameter int unsigned N_SEQ   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [N_SEQ-1:0] seq_req_en,
  input  lpcm_item         seq_req [N_SEQ],
  output logic [N_SEQ-1:0] seq_gnt,
  input  logic [N_SEQ-1:0] seq_done,
  output logic [N_SEQ-1:0] seq_rsp_en,
  output lpcm_item         seq_rsp,
  output logic             drv_req_en,
  output lpcm_item         drv_req,
  input  logic             drv_rsp_en,
  input  lpcm_item         drv_rsp,
  output logic             done,
  output logic             err_timeout,
  output logic             err_stray
);

  localparam int unsigned IW = $clog2(N_SEQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lpcm_arb_state_e state;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   last_sel;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [CW-1:0]   cnt;

  lpcm_rr_picker #(
    .N_SEQ(N_SEQ)
  ) u_picker (
    .req  (seq_req_en),
    .last (last_sel),
    .valid(pick_valid),
    .index(pick_idx)
  );

  // Arbiter FSM. Grant/strobe outputs are registered on the transition into the
  // state they belong to, so they are high for exactly the ISSUE cycle or the
  // cycle after the response; drv_req doubles as the captured item register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      sel         <= '0;
      last_sel    <= IW'(N_SEQ - 1);
      cnt         <= '0;
      seq_gnt     <= '0;
      seq_rsp_en  <= '0;
      seq_rsp     <= '0;
      drv_req_en  <= 1'b0;
      drv_req     <= '0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      seq_gnt    <= '0;
      seq_rsp_en <= '0;
      drv_req_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (drv_rsp_en) begin
            err_stray <= 1'b1;
          end
          if (pick_valid) begin
            sel        <= pick_idx;
            drv_req    <= seq_req[pick_idx];
            drv_req_en <= 1'b1;
            seq_gnt    <= N_SEQ'(1) << pick_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (drv_rsp_en) begin
            err_stray <= 1'b1;
          end
          cnt   <= '0;
          state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (drv_rsp_en) begin
            seq_rsp    <= drv_rsp;
            seq_rsp_en <= N_SEQ'(1) << sel;
            last_sel   <= sel;
            state      <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            last_sel    <= sel;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All sequencers finished, nothing pending, nothing in flight; forced low in reset.
  always_comb begin
    done = resetb && (state == IDLE) && (&seq_done) && !(|seq_req_en);
  end

endmodule

// File: tb/tb_lpcm_seq_arbiter.sv
// Self-checking bench for lpcm_seq_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_lpcm_seq_arbiter;
  import lpcm_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           resetb;
  logic [N-1:0]   seq_req_en;
  lpcm_item       seq_req [N];
  logic [N-1:0]   seq_gnt;
  logic [N-1:0]   seq_done;
  logic [N-1:0]   seq_rsp_en;
  lpcm_item       seq_rsp;
  logic           drv_req_en;
  lpcm_item       drv_req;
  logic           drv_rsp_en;
  lpcm_item       drv_rsp;
  logic           done;
  logic           err_timeout;
  logic           err_stray;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: who was served last, and the sticky error flags.
  int m_last;
  bit m_err_to;
  bit m_err_stray;

  always #5 clk = ~clk;

  lpcm_seq_arbiter #(
    .N_SEQ  (N),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .seq_req_en (seq_req_en),
    .seq_req    (seq_req),
    .seq_gnt    (seq_gnt),
    .seq_done   (seq_done),
    .seq_rsp_en (seq_rsp_en),
    .seq_rsp    (seq_rsp),
    .drv_req_en (drv_req_en),
    .drv_req    (drv_req),
    .drv_rsp_en (drv_rsp_en),
    .drv_rsp    (drv_rsp),
    .done       (done),
    .err_timeout(err_timeout),
    .err_stray  (err_stray)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic lpcm_item rand_item();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[$bits(lpcm_item)-1:0];
  endfunction

  // Round-robin rule: first requester strictly after the last one served.
  function automatic int rr_winner(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic chk_flags(input string tag);
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(m_err_to));
    chk({tag, "_err_stray"}, 64'(err_stray), 64'(m_err_stray));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(seq_gnt), 64'd0);
    chk({tag, "_rsp_en"}, 64'(seq_rsp_en), 64'd0);
    chk({tag, "_rsp"}, 64'(seq_rsp), 64'd0);
    chk({tag, "_drv_req_en"}, 64'(drv_req_en), 64'd0);
    chk({tag, "_drv_req"}, 64'(drv_req), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
    chk({tag, "_err_stray"}, 64'(err_stray), 64'd0);
  endtask

  // One transaction starting from an idle arbiter at a negedge. delay = cycles
  // after the issue cycle at which the driver answers; delay > TO means silent.
  task automatic run_txn(input logic [N-1:0] mask, input int delay, input logic [N-1:0] done_v);
    lpcm_item items [N];
    lpcm_item rsp;
    int w;
    for (int i = 0; i < N; i++) begin
      items[i]   = rand_item();
      seq_req[i] = items[i];
    end
    rsp        = rand_item();
    seq_done   = done_v;
    seq_req_en = '0;
    #1;
    chk("done_idle", 64'(done), 64'(&done_v));
    seq_req_en = mask;
    #1;
    chk("done_req", 64'(done), 64'd0);
    w = rr_winner(mask, m_last);
    step();
    chk("gnt", 64'(seq_gnt), 64'd1 << w);
    chk("drv_req_en", 64'(drv_req_en), 64'd1);
    chk("drv_req", 64'(drv_req), 64'(items[w]));
    seq_req_en = '0;
    for (int c = 1; c <= TO; c++) begin
      step();
      chk("wait_gnt", 64'(seq_gnt), 64'd0);
      chk("wait_drv_req_en", 64'(drv_req_en), 64'd0);
      chk("wait_rsp_en", 64'(seq_rsp_en), 64'd0);
      chk("wait_done", 64'(done), 64'd0);
      if (c == delay) begin
        drv_rsp    = rsp;
        drv_rsp_en = 1'b1;
        step();
        drv_rsp_en = 1'b0;
        chk("rsp_en", 64'(seq_rsp_en), 64'd1 << w);
        chk("rsp_data", 64'(seq_rsp), 64'(rsp));
        chk_flags("rsp");
        m_last = w;
        return;
      end
    end
    chk("to_not_early", 64'(err_timeout), 64'(m_err_to));
    step();
    m_err_to = 1'b1;
    m_last   = w;
    chk("to_flag", 64'(err_timeout), 64'd1);
    chk("to_rsp_en", 64'(seq_rsp_en), 64'd0);
    chk_flags("to");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    lpcm_item it;
    resetb      = 1'b0;
    seq_req_en  = '0;
    seq_done    = '1;
    drv_rsp_en  = 1'b0;
    drv_rsp     = '0;
    for (int i = 0; i < N; i++) seq_req[i] = '0;
    m_last      = N - 1;
    m_err_to    = 1'b0;
    m_err_stray = 1'b0;

    // Reset state, including done held low despite all seq_done high.
    step();
    step();
    chk_all_zero("reset");
    resetb = 1'b1;
    step();

    // Everyone requesting, driver answers two cycles after issue: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) run_txn(4'b1111, 2, 4'b1111);

    // Single requester, response four cycles after issue.
    run_txn(4'b0001, 4, 4'b0000);

    // Response on the very last waiting cycle is still accepted.
    run_txn(4'b1111, TO, 4'b1111);

    // Silent driver: timeout, then the next requester in rotation is served.
    run_txn(4'b1111, TO + 1, 4'b0101);
    run_txn(4'b1111, 3, 4'b1111);

    // Stray response while idle.
    drv_rsp    = rand_item();
    drv_rsp_en = 1'b1;
    step();
    drv_rsp_en  = 1'b0;
    m_err_stray = 1'b1;
    chk("stray_flag", 64'(err_stray), 64'd1);
    chk("stray_rsp_en", 64'(seq_rsp_en), 64'd0);
    chk("stray_drv_req_en", 64'(drv_req_en), 64'd0);
    run_txn(4'b0110, 1, 4'b1111);

    // Randomized traffic.
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0] mask;
      logic [N-1:0] dv;
      mask = N'($urandom_range(1, (1 << N) - 1));
      dv   = ($urandom_range(0, 1) == 1) ? '1 : N'($urandom);
      run_txn(mask, $urandom_range(1, TO + 3), dv);
    end

    // Reset while sequencer 2 is waiting for its response.
    it         = rand_item();
    seq_req[2] = it;
    seq_done   = '1;
    seq_req_en = 4'b0100;
    m_last     = (m_last == 2) ? 2 : m_last;
    step();
    chk("mid_gnt", 64'(seq_gnt), 64'd1 << rr_winner(4'b0100, m_last));
    seq_req_en = '0;
    step();
    step();
    resetb = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    m_last      = N - 1;
    m_err_to    = 1'b0;
    m_err_stray = 1'b0;
    step();
    resetb = 1'b1;
    step();
    drv_rsp    = rand_item();
    drv_rsp_en = 1'b1;
    step();
    drv_rsp_en  = 1'b0;
    m_err_stray = 1'b1;
    chk("late_rsp_stray", 64'(err_stray), 64'd1);
    chk("late_rsp_en", 64'(seq_rsp_en), 64'd0);
    chk("late_err_timeout", 64'(err_timeout), 64'd0);
    run_txn(4'b0101, 3, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
